irq_prio_arbiter: RTL and testbench

- Parametrised, clocked successor to the 27-channel combinational interrupt priority decoder.
- Requests arrive as NBUS request buses of NCH channels each, with one enable mask shared across buses. Rising request edges are latched as sticky pending bits.
- A registered arbiter selects one winning bus and channel, then presents it through a valid/ack handshake.
- Sits between peripheral interrupt lines and the interrupt-service sequencer.

---
 rtl/irq_prio_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_irq_prio_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_prio_arbiter.sv
// irq_prio_arbiter: latches rising request edges from NBUS buses of NCH
// channels into sticky pending bits and presents one winner at a time
// through a valid/ack handshake.
// Optional macro IRQ_PRIO_RR_EN: per-bus round-robin channel search.
// Without it, channel priority is fixed (lowest index wins).
//
// Handshake: irq_valid is high exactly while the FSM is in GRANT.
// irq_bus/irq_chan are stable for as long as irq_valid is high. The
// interrupt is consumed on the rising CK edge where irq_valid and irq_ack
// are both high. irq_ack is ignored while irq_valid is low.
module irq_prio_arbiter #(
  parameter int NBUS = 3,
  parameter int NCH  = 9,
  parameter int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 CK,
  input  logic                 RN,
  input  logic [NBUS*NCH-1:0]  req,
  input  logic [NCH-1:0]       en_mask,
  input  logic                 irq_ack,
  output logic                 irq_valid,
  output logic [NBUS-1:0]      irq_bus,
  output logic [CHW-1:0]       irq_chan,
  output logic [NBUS*NCH-1:0]  pend,
  output logic                 busy
);

  localparam int NB = NBUS * NCH;
  localparam int BW = (NBUS > 1) ? $clog2(NBUS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    GRANT = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [NB-1:0]  req_q;
  logic [NB-1:0]  rise;
  logic [NB-1:0]  elig;
  logic [NB-1:0]  clr;
  logic           any_elig;
  logic           load_win;
  logic           do_ack;
  logic [BW-1:0]  gnt_bus;
  logic [BW-1:0]  win_bus;
  logic [NBUS-1:0] win_onehot;
  logic [NCH-1:0] bus_elig;
  logic [CHW-1:0] win_chan;

`ifdef IRQ_PRIO_RR_EN
  localparam logic [CHW:0] NCH_W = (CHW+1)'(NCH);
  logic [CHW-1:0] rr [NBUS];
  logic [CHW-1:0] bus_start;
  logic [NCH-1:0] rot;
  logic [CHW-1:0] off;
  logic [CHW:0]   chan_sum;
  logic [CHW:0]   rr_sum;
  logic [CHW-1:0] rr_nxt;
`endif

  assign rise     = req & ~req_q;
  assign elig     = pend & {NBUS{en_mask}};
  assign any_elig = |elig;

  assign irq_valid = (state == GRANT);
  assign busy      = (state != IDLE);

  // Bus selection: lowest-index bus with any eligible channel wins.
  always_comb begin
    win_bus    = '0;
    win_onehot = '0;
    bus_elig   = '0;
`ifdef IRQ_PRIO_RR_EN
    bus_start  = '0;
`endif
    for (int b = NBUS - 1; b >= 0; b--) begin
      if (|elig[b*NCH +: NCH]) begin
        win_bus       = BW'(b);
        win_onehot    = '0;
        win_onehot[b] = 1'b1;
        bus_elig      = elig[b*NCH +: NCH];
`ifdef IRQ_PRIO_RR_EN
        bus_start     = rr[b];
`endif
      end
    end
  end

`ifdef IRQ_PRIO_RR_EN
  // Channel selection: first eligible channel at or after the bus pointer, wrapping.
  always_comb begin
    rot = NCH'({bus_elig, bus_elig} >> bus_start);
    off = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (rot[k]) off = CHW'(k);
    end
    chan_sum = {1'b0, bus_start} + {1'b0, off};
    if (chan_sum >= NCH_W) chan_sum = chan_sum - NCH_W;
    win_chan = chan_sum[CHW-1:0];
  end

  // Pointer advance value: one past the granted channel, modulo NCH.
  always_comb begin
    rr_sum = {1'b0, irq_chan} + (CHW+1)'(1);
    if (rr_sum >= NCH_W) rr_sum = '0;
    rr_nxt = rr_sum[CHW-1:0];
  end

  // Round-robin pointers advance only when a grant is acknowledged.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      for (int b = 0; b < NBUS; b++) rr[b] <= '0;
    end else if (do_ack) begin
      rr[gnt_bus] <= rr_nxt;
    end
  end
`else
  // Channel selection: lowest eligible channel index within the winning bus.
  always_comb begin
    win_chan = '0;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (bus_elig[c]) win_chan = CHW'(c);
    end
  end
`endif

  // Next-state logic; the winner is latched only on the ARB->GRANT move.
  always_comb begin
    state_nxt = state;
    load_win  = 1'b0;
    do_ack    = 1'b0;
    case (state)
      IDLE:  if (any_elig) state_nxt = ARB;
      ARB: begin
        if (any_elig) begin
          load_win  = 1'b1;
          state_nxt = GRANT;
        end else begin
          state_nxt = IDLE;
        end
      end
      GRANT: begin
        if (irq_ack) begin
          do_ack    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One-hot clear of the granted pending bit on the acknowledge edge.
  always_comb begin
    clr = '0;
    if (do_ack) begin
      for (int b = 0; b < NBUS; b++) begin
        for (int c = 0; c < NCH; c++) begin
          if (gnt_bus == BW'(b) && irq_chan == CHW'(c)) clr[b*NCH + c] = 1'b1;
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) state <= IDLE;
    else     state <= state_nxt;
  end

  // Edge capture and sticky pending bits; a new edge beats a same-cycle clear.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      req_q <= '0;
      pend  <= '0;
    end else begin
      req_q <= req;
      pend  <= (pend & ~clr) | rise;
    end
  end

  // Winner registers, held stable through GRANT.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      irq_bus  <= '0;
      irq_chan <= '0;
      gnt_bus  <= '0;
    end else if (load_win) begin
      irq_bus  <= win_onehot;
      irq_chan <= win_chan;
      gnt_bus  <= win_bus;
    end
  end

endmodule

// File: tb/tb_irq_prio_arbiter.sv
// Bench for irq_prio_arbiter: directed steps followed by random traffic,
// all checked each cycle against a transaction-level reference model.
module tb_irq_prio_arbiter;

  localparam int NBUS = 3;
  localparam int NCH  = 9;
  localparam int CHW  = 4;
  localparam int NB   = NBUS * NCH;

  // Clock and reset
  logic            CK = 1'b0;
  logic            RN = 1'b0;
  logic [NB-1:0]   req = '0;
  logic [NCH-1:0]  en_mask = '0;
  logic            irq_ack = 1'b0;
  logic            irq_valid;
  logic [NBUS-1:0] irq_bus;
  logic [CHW-1:0]  irq_chan;
  logic [NB-1:0]   pend;
  logic            busy;

  always #5 CK = ~CK;

  irq_prio_arbiter #(.NBUS(NBUS), .NCH(NCH)) dut (
    .CK(CK), .RN(RN), .req(req), .en_mask(en_mask), .irq_ack(irq_ack),
    .irq_valid(irq_valid), .irq_bus(irq_bus), .irq_chan(irq_chan),
    .pend(pend), .busy(busy)
  );

  int compared = 0;
  int mismatched = 0;

  // Reference model: pending set as bit arrays, a grant phase counter
  // (0 waiting, 1 deciding, 2 presenting) and the current winner.
  bit m_prev [NB];
  bit m_pend [NB];
  int m_phase;
  int m_bus;
  int m_chan;
  logic [NBUS-1:0] m_bus_oh;
  int m_rr [NBUS];

  function automatic void model_reset();
    for (int i = 0; i < NB; i++) begin
      m_prev[i] = 0;
      m_pend[i] = 0;
    end
    for (int b = 0; b < NBUS; b++) m_rr[b] = 0;
    m_phase = 0; m_bus = 0; m_chan = 0; m_bus_oh = '0;
  endfunction

  function automatic bit is_elig(int i);
    return m_pend[i] && en_mask[i % NCH];
  endfunction

  function automatic bit pick(output int wb, output int wc);
    wb = 0; wc = 0;
    for (int b = 0; b < NBUS; b++) begin
      for (int k = 0; k < NCH; k++) begin
        int c;
`ifdef IRQ_PRIO_RR_EN
        c = (m_rr[b] + k) % NCH;
`else
        c = k;
`endif
        if (is_elig(b * NCH + c)) begin
          wb = b; wc = c;
          return 1'b1;
        end
      end
    end
    return 1'b0;
  endfunction

  // Advance the model by one clock edge using the inputs as currently driven.
  function automatic void model_step();
    int wb, wc;
    bit any;
    any = pick(wb, wc);
    case (m_phase)
      0: if (any) m_phase = 1;
      1: begin
        if (any) begin
          m_bus = wb; m_chan = wc; m_bus_oh = NBUS'(1) << wb; m_phase = 2;
        end else begin
          m_phase = 0;
        end
      end
      default: begin
        if (irq_ack) begin
          m_pend[m_bus * NCH + m_chan] = 0;
          m_rr[m_bus] = (m_chan + 1) % NCH;
          m_phase = 0;
        end
      end
    endcase
    for (int i = 0; i < NB; i++) begin
      if (req[i] && !m_prev[i]) m_pend[i] = 1;
      m_prev[i] = req[i];
    end
  endfunction

  // Scoreboard comparison
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [NB-1:0] ep;
    for (int i = 0; i < NB; i++) ep[i] = m_pend[i];
    chk("pend", pend, ep);
    chk("irq_valid", irq_valid, (m_phase == 2));
    chk("busy", busy, (m_phase != 0));
    chk("irq_bus", irq_bus, m_bus_oh);
    chk("irq_chan", irq_chan, m_chan);
  endtask

  // Driver: one clock edge, model in lockstep, outputs sampled 1 time unit later.
  task automatic tick();
    if (!RN) model_reset();
    else     model_step();
    @(posedge CK);
    #1;
    check_all();
  endtask

  task automatic wait_valid(input string tag, input int max_cycles);
    int n = 0;
    while (!irq_valid && n < max_cycles) begin
      tick();
      n++;
    end
    chk(tag, irq_valid, 1'b1);
  endtask

  task automatic ack_once();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  int pb [3] = '{1, 1, 2};
  int pc [3] = '{1, 3, 4};
  int rr_exp [3];
  int got_chan [3];
  int got;

  initial begin
    model_reset();
    #1;
    tick();
    tick();
    chk("reset_valid", irq_valid, 1'b0);
    chk("reset_pend", pend, '0);
    chk("reset_busy", busy, 1'b0);
    RN = 1'b1;
    en_mask = 9'h1FF;
    tick();

    // Single request on bus 1, channel 4: two cycles from pend to valid.
    req[13] = 1'b1;
    tick();
    req[13] = 1'b0;
    chk("single_pend13", pend[13], 1'b1);
    chk("single_no_valid_e0", irq_valid, 1'b0);
    tick();
    chk("single_busy_e1", busy, 1'b1);
    chk("single_no_valid_e1", irq_valid, 1'b0);
    tick();
    chk("single_valid_e2", irq_valid, 1'b1);
    chk("single_bus", irq_bus, 3'b010);
    chk("single_chan", irq_chan, 4);
    ack_once();
    chk("single_pend_clr", pend[13], 1'b0);
    chk("single_valid_drop", irq_valid, 1'b0);

    // Fixed priority among three simultaneous requests.
    req[22] = 1'b1; req[10] = 1'b1; req[12] = 1'b1;
    tick();
    req = '0;
    for (int g = 0; g < 3; g++) begin
      wait_valid("prio_wait", 10);
      chk("prio_bus", irq_bus, NBUS'(1) << pb[g]);
      chk("prio_chan", irq_chan, pc[g]);
      ack_once();
    end
    tick();
    chk("prio_pend_empty", pend, '0);

    // Masked request stays pending without a grant until unmasked.
    en_mask = 9'h1FE;
    req[0] = 1'b1;
    tick();
    req[0] = 1'b0;
    repeat (5) tick();
    chk("mask_pend0", pend[0], 1'b1);
    chk("mask_no_grant", irq_valid, 1'b0);
    en_mask = 9'h1FF;
    wait_valid("mask_wait", 10);
    chk("mask_bus", irq_bus, 3'b001);
    chk("mask_chan", irq_chan, 0);
    ack_once();

    // New edge on the granted bit in its ack cycle keeps it pending.
    req[5] = 1'b1;
    wait_valid("sc_wait1", 10);
    chk("sc_chan1", irq_chan, 5);
    req[5] = 1'b0;
    tick();
    req[5] = 1'b1;
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("sc_pend5_kept", pend[5], 1'b1);
    chk("sc_valid_drop", irq_valid, 1'b0);
    wait_valid("sc_wait2", 10);
    chk("sc_bus2", irq_bus, 3'b001);
    chk("sc_chan2", irq_chan, 5);
    ack_once();
    chk("sc_pend5_clr", pend[5], 1'b0);
    req[5] = 1'b0;
    tick();

    // Asynchronous reset during a grant.
    req[3] = 1'b1;
    tick();
    req[3] = 1'b0;
    wait_valid("ar_wait", 10);
    #2;
    RN = 1'b0;
    #1;
    chk("ar_valid_async", irq_valid, 1'b0);
    chk("ar_pend_async", pend, '0);
    chk("ar_busy_async", busy, 1'b0);
    model_reset();
    tick();
    tick();
    RN = 1'b1;
    repeat (6) tick();
    chk("ar_no_spurious", irq_valid, 1'b0);

    // Ack held high: each grant lasts one cycle.
    irq_ack = 1'b1;
    req[20] = 1'b1;
    tick();
    req[20] = 1'b0;
    wait_valid("hold_wait", 10);
    tick();
    chk("hold_one_cycle", irq_valid, 1'b0);

    // Channels 0 and 1 on bus 0 re-raised continuously, ack held.
`ifdef IRQ_PRIO_RR_EN
    rr_exp = '{0, 1, 0};
`else
    rr_exp = '{0, 0, 0};
`endif
    got = 0;
    for (int n = 0; n < 40 && got < 3; n++) begin
      req[0] = ~req[0];
      req[1] = ~req[1];
      tick();
      if (irq_valid) begin
        got_chan[got] = irq_chan;
        got++;
      end
    end
    chk("rr_grant_count", got, 3);
    for (int g = 0; g < got; g++) chk("rr_grant_chan", got_chan[g], rr_exp[g]);
    req = '0;
    irq_ack = 1'b0;
    tick();

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NB; i++) req[i] = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) en_mask = NCH'($urandom_range(0, 511));
      irq_ack = ($urandom_range(0, 1) == 1);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
